// File: rtl/tdc_readout_arbiter.sv
// Merges two TDC RAM write streams through per-channel FIFOs onto one shared RAM port, round-robin,
// and gates each channel's frame-ready until its words are written. Optional drop counters: TDC_ARB_DROPCNT_EN.
module tdc_readout_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic              SYSCLK,
   input  logic              RESET_N,
   input  logic [DATA_W-1:0] ch1_data,
   input  logic [ADDR_W-1:0] ch1_addr,
   input  logic              ch1_we,
   input  logic              ch1_hs_in,
   output logic              ch1_hs_out,
   input  logic [DATA_W-1:0] ch2_data,
   input  logic [ADDR_W-1:0] ch2_addr,
   input  logic              ch2_we,
   input  logic              ch2_hs_in,
   output logic              ch2_hs_out,
   output logic [DATA_W-1:0] ram_data,
   output logic [ADDR_W:0]   ram_addr,
   output logic              ram_we,
   input  logic              clr_ovf,
   output logic [1:0]        ovf
`ifdef TDC_ARB_DROPCNT_EN
   ,
   output logic [15:0]       drop_cnt1,
   output logic [15:0]       drop_cnt2
`endif
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = ADDR_W + DATA_W;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {HS_IDLE, HS_DRAIN, HS_READY} hs_state_t;

   logic [DATA_W-1:0] data_in [2];
   logic [ADDR_W-1:0] addr_in [2];
   logic [ENT_W-1:0]  fifo_rdata [2];
   logic [1:0]        we_in, hs_in, hs_out, nonempty, pop, push_ok, drop, ovf_w;

   logic              last_grant_q, last_grant_d;   // 0 = ch1 served last, 1 = ch2
   logic              ram_we_q, ram_we_d;
   logic              out_ch_q, out_ch_d;
   logic [DATA_W-1:0] ram_data_q, ram_data_d;
   logic [ADDR_W:0]   ram_addr_q, ram_addr_d;
   logic [ENT_W-1:0]  sel_entry;

   assign data_in[0] = ch1_data;
   assign data_in[1] = ch2_data;
   assign addr_in[0] = ch1_addr;
   assign addr_in[1] = ch2_addr;
   assign we_in      = {ch2_we, ch1_we};
   assign hs_in      = {ch2_hs_in, ch1_hs_in};
   assign ch1_hs_out = hs_out[0];
   assign ch2_hs_out = hs_out[1];

`ifdef TDC_ARB_DROPCNT_EN
   logic [15:0] drop_cnt_w [2];
   assign drop_cnt1 = drop_cnt_w[0];
   assign drop_cnt2 = drop_cnt_w[1];
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ch
         logic [ENT_W-1:0] mem [DEPTH];
         logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
         logic [CNT_W-1:0] count_q, count_d;
         logic             ovf_q, ovf_d;
         hs_state_t        hs_state_q, hs_state_d;
         logic             drained;

         // A full FIFO still accepts a word when it is being popped in the same cycle.
         assign push_ok[gi]    = we_in[gi] & ((count_q != FULL_CNT) | pop[gi]);
         assign drop[gi]       = we_in[gi] & ~push_ok[gi];
         assign nonempty[gi]   = (count_q != '0);
         assign fifo_rdata[gi] = mem[rd_ptr_q];
         assign drained        = (count_q == '0) && !(ram_we_q && (out_ch_q == 1'(gi)));
         assign ovf_w[gi]      = ovf_q;
         assign hs_out[gi]     = (hs_state_q == HS_READY);

         always_comb begin
            wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok[gi]);
            rd_ptr_d   = rd_ptr_q + PTR_W'(pop[gi]);
            count_d    = count_q + CNT_W'(push_ok[gi]) - CNT_W'(pop[gi]);
            ovf_d      = (clr_ovf ? 1'b0 : ovf_q) | drop[gi];
            hs_state_d = hs_state_q;
            case (hs_state_q)
               HS_IDLE:  if (hs_in[gi]) hs_state_d = HS_DRAIN;
               HS_DRAIN: begin
                  if (!hs_in[gi])   hs_state_d = HS_IDLE;
                  else if (drained) hs_state_d = HS_READY;
               end
               HS_READY: if (!hs_in[gi]) hs_state_d = HS_IDLE;
               default:  hs_state_d = HS_IDLE;
            endcase
         end

         always_ff @(posedge SYSCLK or negedge RESET_N) begin
            if (!RESET_N) begin
               wr_ptr_q   <= '0;
               rd_ptr_q   <= '0;
               count_q    <= '0;
               ovf_q      <= 1'b0;
               hs_state_q <= HS_IDLE;
            end else begin
               wr_ptr_q   <= wr_ptr_d;
               rd_ptr_q   <= rd_ptr_d;
               count_q    <= count_d;
               ovf_q      <= ovf_d;
               hs_state_q <= hs_state_d;
            end
         end

         always_ff @(posedge SYSCLK) begin
            if (push_ok[gi]) mem[wr_ptr_q] <= {addr_in[gi], data_in[gi]};
         end

`ifdef TDC_ARB_DROPCNT_EN
         logic [15:0] drop_cnt_q, drop_cnt_d;

         always_comb begin
            if (clr_ovf)                                   drop_cnt_d = {15'd0, drop[gi]};
            else if (drop[gi] && drop_cnt_q != 16'hFFFF)   drop_cnt_d = drop_cnt_q + 16'd1;
            else                                           drop_cnt_d = drop_cnt_q;
         end

         always_ff @(posedge SYSCLK or negedge RESET_N) begin
            if (!RESET_N) drop_cnt_q <= '0;
            else          drop_cnt_q <= drop_cnt_d;
         end

         assign drop_cnt_w[gi] = drop_cnt_q;
`endif
      end
   endgenerate

   // Round-robin only matters under contention; a lone non-empty FIFO is always served.
   always_comb begin
      last_grant_d = last_grant_q;
      if (nonempty == 2'b11) pop = last_grant_q ? 2'b01 : 2'b10;
      else                   pop = nonempty;
      if (pop != 2'b00) last_grant_d = pop[1];
      sel_entry  = pop[1] ? fifo_rdata[1] : fifo_rdata[0];
      ram_we_d   = |pop;
      out_ch_d   = pop[1];
      ram_data_d = ram_data_q;
      ram_addr_d = ram_addr_q;
      if (|pop) begin
         ram_data_d = sel_entry[DATA_W-1:0];
         ram_addr_d = {pop[1], sel_entry[ENT_W-1:DATA_W]};
      end
   end

   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         last_grant_q <= 1'b1;
         ram_we_q     <= 1'b0;
         out_ch_q     <= 1'b0;
         ram_data_q   <= '0;
         ram_addr_q   <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         ram_we_q     <= ram_we_d;
         out_ch_q     <= out_ch_d;
         ram_data_q   <= ram_data_d;
         ram_addr_q   <= ram_addr_d;
      end
   end

   assign ram_we   = ram_we_q;
   assign ram_data = ram_data_q;
   assign ram_addr = ram_addr_q;
   assign ovf      = ovf_w;
endmodule

// File: tb/tb_tdc_readout_arbiter.sv
// Directed bench for tdc_readout_arbiter: single word, contention, overflow, handshake, abort, reset.
module tb_tdc_readout_arbiter;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 16;

   logic              SYSCLK = 1'b0;
   logic              RESET_N = 1'b0;
   logic [DATA_W-1:0] ch1_data = '0, ch2_data = '0;
   logic [ADDR_W-1:0] ch1_addr = '0, ch2_addr = '0;
   logic              ch1_we = 1'b0, ch2_we = 1'b0;
   logic              ch1_hs_in = 1'b0, ch2_hs_in = 1'b0;
   logic              ch1_hs_out, ch2_hs_out;
   logic [DATA_W-1:0] ram_data;
   logic [ADDR_W:0]   ram_addr;
   logic              ram_we;
   logic              clr_ovf = 1'b0;
   logic [1:0]        ovf;
`ifdef TDC_ARB_DROPCNT_EN
   logic [15:0]       drop_cnt1, drop_cnt2;
`endif

   tdc_readout_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .SYSCLK(SYSCLK), .RESET_N(RESET_N),
      .ch1_data(ch1_data), .ch1_addr(ch1_addr), .ch1_we(ch1_we),
      .ch1_hs_in(ch1_hs_in), .ch1_hs_out(ch1_hs_out),
      .ch2_data(ch2_data), .ch2_addr(ch2_addr), .ch2_we(ch2_we),
      .ch2_hs_in(ch2_hs_in), .ch2_hs_out(ch2_hs_out),
      .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we),
      .clr_ovf(clr_ovf), .ovf(ovf)
`ifdef TDC_ARB_DROPCNT_EN
      , .drop_cnt1(drop_cnt1), .drop_cnt2(drop_cnt2)
`endif
   );

   always #5 SYSCLK = ~SYSCLK;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   typedef struct {
      int                c;
      logic [ADDR_W:0]   a;
      logic [DATA_W-1:0] d;
   } obs_t;
   obs_t obs_q[$];

   always @(posedge SYSCLK) cyc <= cyc + 1;

   always @(negedge SYSCLK) begin
      if (ram_we) begin
         obs_q.push_back('{cyc, ram_addr, ram_data});
         $display("[cyc %0d] ram write addr=0x%03h data=0x%08h", cyc, ram_addr, ram_data);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge SYSCLK);
      #1;
   endtask

   task automatic idle_inputs();
      ch1_we = 0; ch2_we = 0; ch1_hs_in = 0; ch2_hs_in = 0; clr_ovf = 0;
      ch1_data = '0; ch2_data = '0; ch1_addr = '0; ch2_addr = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      RESET_N = 0;
      tick();
      tick();
      RESET_N = 1;
      tick();
      obs_q.delete();
   endtask

   initial begin
      int s, rise, n1, n2;
      logic hs_seen;

      // Reset state
      idle_inputs();
      tick();
      tick();
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_data", ram_data, 0);
      check("rst_ovf", ovf, 0);
      check("rst_hs_out", {ch2_hs_out, ch1_hs_out}, 0);
      RESET_N = 1;
      tick();

      // Single word
      obs_q.delete();
      ch1_we = 1; ch1_addr = 8'h05; ch1_data = 32'hDEADBEEF;
      tick();
      ch1_we = 0;
      check("single_lat_we0", ram_we, 0);
      tick();
      check("single_we", ram_we, 1);
      check("single_addr", ram_addr, 9'h005);
      check("single_data", ram_data, 32'hDEADBEEF);
      tick();
      check("single_we_off", ram_we, 0);
      check("single_count", obs_q.size(), 1);

      // Contention: 8 words each, alternating starting with ch1
      do_reset();
      s = cyc;
      for (int i = 0; i < 8; i++) begin
         ch1_we = 1; ch1_addr = ADDR_W'(i);        ch1_data = 32'h1000 + 32'(i);
         ch2_we = 1; ch2_addr = ADDR_W'(8'h10 + i); ch2_data = 32'h2000 + 32'(i);
         tick();
      end
      ch1_we = 0; ch2_we = 0;
      repeat (12) tick();
      check("cont_count", obs_q.size(), 16);
      if (obs_q.size() == 16) begin
         for (int j = 0; j < 16; j++) begin
            int ch, n;
            ch = j % 2;
            n  = j / 2;
            check($sformatf("cont_cyc%0d", j), obs_q[j].c, s + 2 + j);
            check($sformatf("cont_addr%0d", j), obs_q[j].a,
                  (ch == 1) ? (9'h100 | 9'(8'h10 + n)) : 9'(n));
            check($sformatf("cont_data%0d", j), obs_q[j].d,
                  (ch == 1) ? 32'h2000 + 32'(n) : 32'h1000 + 32'(n));
         end
      end

      // Overflow: both channels write 40 words; clr_ovf coincides with a ch2 drop
      do_reset();
      for (int n = 0; n < 40; n++) begin
         ch1_we = 1; ch1_addr = ADDR_W'(n); ch1_data = 32'h3000 + 32'(n);
         ch2_we = 1; ch2_addr = ADDR_W'(n); ch2_data = 32'h4000 + 32'(n);
         clr_ovf = (n == 33);
         tick();
         if (n == 30) check("ovf_full_pop_ok", ovf, 2'b00);
         if (n == 32) check("ovf_both_set", ovf, 2'b11);
         if (n == 33) begin
            check("ovf_clr_with_drop", ovf, 2'b10);
`ifdef TDC_ARB_DROPCNT_EN
            check("dcnt2_clr_with_drop", drop_cnt2, 1);
            check("dcnt1_clr", drop_cnt1, 0);
`endif
         end
      end
      idle_inputs();
      repeat (80) tick();
      n1 = 0; n2 = 0;
      foreach (obs_q[j]) begin
         if (obs_q[j].a[ADDR_W]) n2++;
         else                    n1++;
      end
      check("ovf_ch1_written", n1, 36);
      check("ovf_ch2_dropped", 40 - n2, 5);
      check("ovf_after_burst", ovf, 2'b11);
`ifdef TDC_ARB_DROPCNT_EN
      check("dcnt1_after", drop_cnt1, 3);
      check("dcnt2_after", drop_cnt2, 4);
`endif
      clr_ovf = 1;
      tick();
      clr_ovf = 0;
      check("ovf_cleared", ovf, 2'b00);
`ifdef TDC_ARB_DROPCNT_EN
      check("dcnt1_cleared", drop_cnt1, 0);
      check("dcnt2_cleared", drop_cnt2, 0);
`endif

      // Handshake ordering: 10 ch1 words then frame ready
      do_reset();
      for (int i = 0; i < 10; i++) begin
         ch1_we = 1; ch1_addr = ADDR_W'(8'h20 + i); ch1_data = 32'hA000 + 32'(i);
         tick();
      end
      ch1_we = 0;
      ch1_hs_in = 1;
      rise = -1;
      for (int k = 0; k < 40 && rise < 0; k++) begin
         tick();
         if (ch1_hs_out) rise = cyc;
      end
      check("hs1_rise_seen", rise >= 0, 1);
      check("hs1_words", obs_q.size(), 10);
      if (obs_q.size() == 10) begin
         check("hs1_last_data", obs_q[9].d, 32'hA009);
         check("hs1_rise_after_last", rise, obs_q[9].c + 2);
      end
      tick();
      check("hs1_hold", ch1_hs_out, 1);
      ch1_hs_in = 0;
      tick();
      check("hs1_fall", ch1_hs_out, 0);

      // Abort: ch2_hs_in high for 2 cycles while ch2 words are queued
      do_reset();
      hs_seen = 0;
      for (int i = 0; i < 6; i++) begin
         ch2_we = 1; ch2_addr = ADDR_W'(8'h30 + i); ch2_data = 32'hB000 + 32'(i);
         if (i == 2) ch2_hs_in = 1;
         if (i == 4) ch2_hs_in = 0;
         tick();
         hs_seen = hs_seen | ch2_hs_out;
      end
      ch2_we = 0;
      repeat (10) begin
         tick();
         hs_seen = hs_seen | ch2_hs_out;
      end
      check("abort_hs2_never", hs_seen, 0);
      check("abort_words", obs_q.size(), 6);

      // Reset mid-drain
      do_reset();
      for (int i = 0; i < 8; i++) begin
         ch1_we = 1; ch1_addr = ADDR_W'(i); ch1_data = 32'hC000 + 32'(i);
         ch2_we = 1; ch2_addr = ADDR_W'(i); ch2_data = 32'hD000 + 32'(i);
         tick();
      end
      ch1_we = 0; ch2_we = 0;
      check("mid_pre_we", ram_we, 1);
      #2;
      RESET_N = 0;
      #1;
      check("mid_async_we", ram_we, 0);
      check("mid_async_addr", ram_addr, 0);
      tick();
      tick();
      #2;
      RESET_N = 1;
      obs_q.delete();
      repeat (20) tick();
      check("mid_no_residual", obs_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1);
   end
endmodule
